// File: rtl/corr_peak_finder_p.sv
// corr_peak_finder_p
//   Streaming sliding-window correlator. Received samples are correlated
//   against a TAPS-long reference loaded at run time. The block reports the
//   largest correlation of a frame (signed or magnitude) and the lag of the
//   window that produced it. Ties keep the earliest lag.
//
// Ports
//   clk, rst        clock; asynchronous active-high reset
//   ena             global clock enable (low freezes everything, s_ready=0)
//   start           begin a frame (IDLE only); latches n_samples, abs_mode
//   n_samples       frame length in samples
//   abs_mode        0: maximise signed sum, 1: maximise |sum|
//   coef_we/addr/data  coefficient write port (IDLE only, addr < TAPS)
//   s_valid/s_data/s_ready  sample stream handshake
//   busy            high outside IDLE
//   done            end-of-frame strobe (held while ena is low)
//   peak_valid      at least one full window evaluated in the last frame
//   peak_val        signed sum of the winning window
//   peak_lag        index of the first sample of the winning window
module corr_peak_finder_p #(
   parameter int DW   = 8,
   parameter int CW   = 8,
   parameter int TAPS = 20,
   parameter int IW   = 13,
   parameter int ACCW = 21,
   localparam int AW  = $clog2(TAPS)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            ena,
   input  logic            start,
   input  logic [IW-1:0]   n_samples,
   input  logic            abs_mode,
   input  logic            coef_we,
   input  logic [AW-1:0]   coef_addr,
   input  logic [CW-1:0]   coef_data,
   input  logic            s_valid,
   input  logic [DW-1:0]   s_data,
   output logic            s_ready,
   output logic            busy,
   output logic            done,
   output logic            peak_valid,
   output logic [ACCW-1:0] peak_val,
   output logic [IW-1:0]   peak_lag
);

   typedef enum logic [2:0] {S_IDLE, S_FILL, S_MAC, S_CMP, S_DONE} state_t;

   state_t r_state;
   state_t w_next;

   logic signed [CW-1:0]   r_coef [TAPS];
   logic signed [DW-1:0]   r_win  [TAPS];   // r_win[0] is the oldest sample x[L]
   logic [IW-1:0]          r_rxcnt;
   logic [IW-1:0]          r_nsamp;
   logic                   r_abs;
   logic [AW-1:0]          r_idx;
   logic signed [ACCW-1:0] r_acc;
   logic signed [ACCW:0]   r_best;
   logic                   r_peak_valid;
   logic [ACCW-1:0]        r_peak_val;
   logic [IW-1:0]          r_peak_lag;

   logic [IW-1:0]          w_rx_inc;
   logic                   w_short;
   logic                   w_mac_last;
   logic signed [DW+CW-1:0] w_prod;
   logic signed [ACCW-1:0] w_prod_ext;
   logic signed [ACCW:0]   w_acc_ext;
   logic signed [ACCW:0]   w_metric;
   logic                   w_better;

   assign w_rx_inc   = r_rxcnt + 1'b1;
   assign w_short    = n_samples < IW'(TAPS);
   assign w_mac_last = r_idx == AW'(TAPS - 1);
   assign w_prod     = r_win[r_idx] * r_coef[r_idx];
   assign w_prod_ext = {{(ACCW-DW-CW){w_prod[DW+CW-1]}}, w_prod};

   // One extra bit so |most negative acc| stays representable as a positive metric.
   assign w_acc_ext  = {r_acc[ACCW-1], r_acc};
   assign w_metric   = (r_abs && r_acc[ACCW-1]) ? -w_acc_ext : w_acc_ext;
   assign w_better   = w_metric > r_best;

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         r_state <= S_IDLE;
      else if (ena)
         r_state <= w_next;
   end

   // Next-state logic
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: if (start) w_next = w_short ? S_DONE : S_FILL;
         S_FILL: if (s_valid && (w_rx_inc >= IW'(TAPS))) w_next = S_MAC;
         S_MAC:  if (w_mac_last) w_next = S_CMP;
         S_CMP:  w_next = (r_rxcnt == r_nsamp) ? S_DONE : S_FILL;
         S_DONE: w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   // Output logic
   always_comb begin
      s_ready = ena && (r_state == S_FILL);
      busy    = r_state != S_IDLE;
      done    = r_state == S_DONE;
   end

   // Datapath
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned i = 0; i < TAPS; i++) begin
            r_coef[i] <= '0;
            r_win[i]  <= '0;
         end
         r_rxcnt      <= '0;
         r_nsamp      <= '0;
         r_abs        <= 1'b0;
         r_idx        <= '0;
         r_acc        <= '0;
         r_best       <= '0;
         r_peak_valid <= 1'b0;
         r_peak_val   <= '0;
         r_peak_lag   <= '0;
      end else if (ena) begin
         case (r_state)
            S_IDLE: begin
               if (coef_we && (32'(coef_addr) < TAPS))
                  r_coef[coef_addr] <= coef_data;
               if (start) begin
                  r_nsamp      <= n_samples;
                  r_abs        <= abs_mode;
                  r_rxcnt      <= '0;
                  for (int unsigned i = 0; i < TAPS; i++)
                     r_win[i] <= '0;
                  r_peak_valid <= 1'b0;
                  r_peak_val   <= '0;
                  r_peak_lag   <= '0;
                  r_best       <= {1'b1, {ACCW{1'b0}}};
               end
            end
            S_FILL: begin
               if (s_valid) begin
                  for (int unsigned i = 0; i < TAPS - 1; i++)
                     r_win[i] <= r_win[i+1];
                  r_win[TAPS-1] <= s_data;
                  r_rxcnt       <= w_rx_inc;
                  r_acc         <= '0;
                  r_idx         <= '0;
               end
            end
            S_MAC: begin
               r_acc <= r_acc + w_prod_ext;
               r_idx <= r_idx + 1'b1;
            end
            S_CMP: begin
               if (w_better) begin
                  r_best     <= w_metric;
                  r_peak_val <= r_acc;
                  r_peak_lag <= r_rxcnt - IW'(TAPS);
               end
               r_peak_valid <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign peak_valid = r_peak_valid;
   assign peak_val   = r_peak_val;
   assign peak_lag   = r_peak_lag;

endmodule
